// File: rtl/cv32e40p_voter_pkg.sv
// Shared types and constants for the word-wide TMR voter with fault monitoring.
package cv32e40p_voter_pkg;

  typedef enum logic [1:0] {
    VOTER_TMR  = 2'd0,
    VOTER_DMR  = 2'd1,
    VOTER_FAIL = 2'd2
  } voter_mode_e;

  localparam int unsigned NUM_REP = 3;
  localparam int unsigned REP1    = 0;
  localparam int unsigned REP2    = 1;
  localparam int unsigned REP3    = 2;

  function automatic logic two_or_more(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/cv32e40p_voter_maj.sv
// Bitwise 2-of-3 majority of three replica words plus per-replica mismatch flags.
module cv32e40p_voter_maj #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] res1_i,
  input  logic [WIDTH-1:0] res2_i,
  input  logic [WIDTH-1:0] res3_i,
  output logic [WIDTH-1:0] maj_o,
  output logic [2:0]       mismatch_o
);

  assign maj_o = (res1_i & res2_i) | (res1_i & res3_i) | (res2_i & res3_i);

  assign mismatch_o = {res3_i != maj_o, res2_i != maj_o, res1_i != maj_o};

endmodule

// File: rtl/cv32e40p_tmr_voter_mon.sv
// TMR voter with replica fault monitoring, degrading TMR -> DMR -> FAIL.
// Optional diagnostic syndrome capture is built when CV32E40P_VOTER_DIAG_EN is defined.
module cv32e40p_tmr_voter_mon
  import cv32e40p_voter_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned FAULT_THRESH = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] res1_i,
  input  logic [WIDTH-1:0] res2_i,
  input  logic [WIDTH-1:0] res3_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [2:0]       faulty_o,
  output logic [2:0]       failed_o,
  output logic [1:0]       mode_o,
  output logic             uncorr_o,
  output logic [CNT_W-1:0] err_cnt_o
`ifdef CV32E40P_VOTER_DIAG_EN
  ,
  output logic [WIDTH-1:0] diag_syndrome_o,
  output logic [1:0]       diag_replica_o
`endif
);

  localparam int unsigned CONSEC_W = $clog2(FAULT_THRESH + 1);
  localparam logic [CONSEC_W-1:0] THRESH_C = CONSEC_W'(FAULT_THRESH);

  logic [WIDTH-1:0] res [NUM_REP];
  assign res[REP1] = res1_i;
  assign res[REP2] = res2_i;
  assign res[REP3] = res3_i;

  logic [WIDTH-1:0] maj;
  logic [2:0]       maj_mis;

  cv32e40p_voter_maj #(
    .WIDTH (WIDTH)
  ) u_maj (
    .res1_i     (res1_i),
    .res2_i     (res2_i),
    .res3_i     (res3_i),
    .maj_o      (maj),
    .mismatch_o (maj_mis)
  );

  voter_mode_e          mode_q, mode_d;
  logic [2:0]           failed_q, failed_d;
  logic [CONSEC_W-1:0]  consec_q [NUM_REP];
  logic [CONSEC_W-1:0]  consec_d [NUM_REP];
  logic [CONSEC_W-1:0]  dmr_consec_q, dmr_consec_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic                 valid_q;
  logic [WIDTH-1:0]     result_q;
  logic [2:0]           faulty_q;
  logic                 uncorr_q;

  // Lowest (rep_a) and second-lowest (rep_b) surviving replicas.
  logic [1:0] rep_a, rep_b;
  logic       found_a, found_b;

  always_comb begin
    rep_a   = 2'(REP1);
    rep_b   = 2'(REP2);
    found_a = 1'b0;
    found_b = 1'b0;
    for (int k = 0; k < NUM_REP; k++) begin
      if (!failed_q[k]) begin
        if (!found_a) begin
          rep_a   = 2'(k);
          found_a = 1'b1;
        end else if (!found_b) begin
          rep_b   = 2'(k);
          found_b = 1'b1;
        end
      end
    end
  end

  // A clearing cycle is always voted as full TMR.
  voter_mode_e      mode_eff;
  logic [WIDTH-1:0] result_c;
  logic [2:0]       faulty_c;
  logic             uncorr_c;

  always_comb begin
    mode_eff = clear_i ? VOTER_TMR : mode_q;
    result_c = maj;
    faulty_c = maj_mis;
    uncorr_c = two_or_more(maj_mis);
    unique case (mode_eff)
      VOTER_TMR: ;
      VOTER_DMR: begin
        result_c = res[rep_a];
        faulty_c = 3'b000;
        uncorr_c = 1'b0;
        if (res[rep_a] != res[rep_b]) begin
          uncorr_c        = 1'b1;
          faulty_c[rep_a] = 1'b1;
          faulty_c[rep_b] = 1'b1;
        end
      end
      default: begin
        result_c = res[rep_a];
        faulty_c = 3'b000;
        uncorr_c = 1'b1;
      end
    endcase
  end

  logic [2:0] hit;

  always_comb begin
    mode_d       = mode_q;
    failed_d     = failed_q;
    consec_d     = consec_q;
    dmr_consec_d = dmr_consec_q;
    err_cnt_d    = err_cnt_q;
    hit          = 3'b000;
    if (clear_i) begin
      mode_d       = VOTER_TMR;
      failed_d     = 3'b000;
      dmr_consec_d = '0;
      err_cnt_d    = '0;
      for (int k = 0; k < NUM_REP; k++) consec_d[k] = '0;
    end else if (valid_i) begin
      if ((|faulty_c || uncorr_c) && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      unique case (mode_q)
        VOTER_TMR: begin
          for (int k = 0; k < NUM_REP; k++) begin
            if (!faulty_c[k]) begin
              consec_d[k] = '0;
            end else if (consec_q[k] != THRESH_C) begin
              consec_d[k] = consec_q[k] + CONSEC_W'(1);
            end
            hit[k] = faulty_c[k] && (consec_d[k] == THRESH_C);
          end
          failed_d = failed_q | hit;
          if (two_or_more(hit)) begin
            mode_d = VOTER_FAIL;
          end else if (|hit) begin
            mode_d = VOTER_DMR;
          end
        end
        VOTER_DMR: begin
          if (!uncorr_c) begin
            dmr_consec_d = '0;
          end else if (dmr_consec_q != THRESH_C) begin
            dmr_consec_d = dmr_consec_q + CONSEC_W'(1);
          end
          if (uncorr_c && (dmr_consec_d == THRESH_C)) mode_d = VOTER_FAIL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q       <= VOTER_TMR;
      failed_q     <= 3'b000;
      dmr_consec_q <= '0;
      err_cnt_q    <= '0;
      valid_q      <= 1'b0;
      result_q     <= '0;
      faulty_q     <= 3'b000;
      uncorr_q     <= 1'b0;
      for (int k = 0; k < NUM_REP; k++) consec_q[k] <= '0;
    end else begin
      mode_q       <= mode_d;
      failed_q     <= failed_d;
      dmr_consec_q <= dmr_consec_d;
      err_cnt_q    <= err_cnt_d;
      valid_q      <= valid_i;
      faulty_q     <= valid_i ? faulty_c : 3'b000;
      uncorr_q     <= valid_i & uncorr_c;
      if (valid_i) result_q <= result_c;
      for (int k = 0; k < NUM_REP; k++) consec_q[k] <= consec_d[k];
    end
  end

  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign faulty_o  = faulty_q;
  assign failed_o  = failed_q;
  assign mode_o    = mode_q;
  assign uncorr_o  = uncorr_q;
  assign err_cnt_o = err_cnt_q;

`ifdef CV32E40P_VOTER_DIAG_EN
  logic [WIDTH-1:0] diag_syn_q, diag_syn_d;
  logic [1:0]       diag_rep_q, diag_rep_d;

  // First mismatch since reset/clear is frozen; lowest replica index wins.
  always_comb begin
    diag_syn_d = diag_syn_q;
    diag_rep_d = diag_rep_q;
    if (clear_i) begin
      diag_syn_d = '0;
      diag_rep_d = 2'd0;
    end else if (valid_i && (diag_rep_q == 2'd0) && |faulty_c) begin
      for (int k = NUM_REP - 1; k >= 0; k--) begin
        if (faulty_c[k]) begin
          diag_syn_d = res[k] ^ result_c;
          diag_rep_d = 2'(k + 1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      diag_syn_q <= '0;
      diag_rep_q <= 2'd0;
    end else begin
      diag_syn_q <= diag_syn_d;
      diag_rep_q <= diag_rep_d;
    end
  end

  assign diag_syndrome_o = diag_syn_q;
  assign diag_replica_o  = diag_rep_q;
`else
  // Diagnostic capture not built in this configuration.
`endif

endmodule

// File: doc/cv32e40p_tmr_voter_mon.md
Name: cv32e40p_tmr_voter_mon

Overview:
Parametrised word-wide triple-modular-redundancy voter with fault monitoring, for replicated datapath results in the core.
- Performs bitwise 2-of-3 majority on WIDTH-bit results and registers the voted word.
- Tracks per-replica consecutive mismatches and retires a persistently faulty replica.
- Degrades TMR -> DMR -> FAIL, and reports fault status plus a saturating error count.

Parameters:
WIDTH, 32, data width of each replica result
FAULT_THRESH, 4, consecutive valid mismatch cycles (>=1) that retire a replica / declare DMR failure
CNT_W, 8, width of saturating error counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
clear_i  in  1  clears mode, failed flags, counters (sync)
valid_i  in  1  replica results valid this cycle
res1_i  in  WIDTH  replica 1 result
res2_i  in  WIDTH  replica 2 result
res3_i  in  WIDTH  replica 3 result
valid_o  out  1  registered valid_i
result_o  out  WIDTH  registered voted result
faulty_o  out  3  per-replica mismatch vs voted word, this sample
failed_o  out  3  sticky retired-replica flags
mode_o  out  2  0=TMR, 1=DMR, 2=FAIL
uncorr_o  out  1  sample not correctable in current mode
err_cnt_o  out  CNT_W  saturating count of valid samples with any mismatch

Behaviour:
- Reset: all outputs 0, mode TMR, all internal counters 0.
- Latency 1: outputs reflect the sample presented on the previous clk_i edge. When valid_i=0: valid_o=0, faulty_o=0, uncorr_o=0, result_o holds, state/counters hold.
- TMR mode:
  - result = bitwise majority of res1..3.
  - faulty[k] = (res_k != result).
  - uncorr = 2 or more faulty bits set.
  - Per replica, consec[k] increments on a valid mismatch and clears on a valid match.
  - When consec[k] reaches FAULT_THRESH: failed[k]=1 and next mode = DMR.
  - If two or more replicas reach FAULT_THRESH in the same cycle: all of them are flagged and next mode = FAIL.
- DMR mode (replicas a<b are the remaining, non-failed ones):
  - result = res_a.
  - On res_a != res_b: uncorr=1 and faulty[a], faulty[b] both set.
  - dmr_consec counts consecutive disagreeing valid samples and clears on agreement.
  - At FAULT_THRESH: next mode = FAIL. No further replica is retired.
  - Inputs of the failed replica are ignored.
- FAIL mode: result = res of the lowest-index non-failed replica (res1 if none remain); uncorr=1 on every valid sample; faulty_o=0.
- err_cnt: +1 on each valid sample with any faulty bit or uncorr; saturates at 2^CNT_W-1, never wraps.
- Mode transitions only TMR->DMR, TMR->FAIL, DMR->FAIL; only rst_i or clear_i return to TMR.
- clear_i:
  - Priority over counter/mode updates.
  - A valid sample in the same cycle is voted as TMR and registered normally, but does not update consec, err_cnt or failed.
- rst_i has priority over clear_i.

Optional Feature:
CV32E40P_VOTER_DIAG_EN.
- Defined:
  - Adds output diag_syndrome_o (WIDTH) = XOR of the first mismatching replica against the voted word.
  - Adds output diag_replica_o (2) = index (1..3) of that replica; 0 = none captured.
  - Captured on the first mismatch since reset/clear (lowest index wins ties).
  - Held until rst_i or clear_i; both outputs reset to 0.
- Undefined: ports and capture logic absent; all other behaviour identical.

Decomposition:
- Package cv32e40p_voter_pkg: enum voter_mode_e {VOTER_TMR=2'd0, VOTER_DMR=2'd1, VOTER_FAIL=2'd2} and replica-index constants.
- Sub-module cv32e40p_voter_maj: combinational WIDTH-bit majority plus 3-bit mismatch vector, instantiated once.
- Registers, counters and mode FSM live in the top module.

Test Plan:
- Reset: assert rst_i 2 cycles with random inputs -> all outputs 0, mode_o=0.
- All replicas 0xA5A5A5A5, valid_i=1 -> next cycle valid_o=1, result_o=0xA5A5A5A5, faulty_o=000, err_cnt_o=0.
- res2=0xFFFF0000, res1=res3=0x12345678 for 3 valid cycles, then all equal -> result_o=0x12345678 throughout; faulty_o=010 for 3 cycles; err_cnt_o=3; failed_o=000; mode_o=0.
- res3 mismatch on 4 consecutive valid cycles, with valid_i=0 gaps between them -> failed_o=100, mode_o=1 after 4th sample. Then res1=0x1, res2=0x2 -> result_o=0x1, uncorr_o=1, faulty_o=011.
- In DMR, 4 consecutive disagreements -> mode_o=2. Then pulse clear_i -> mode_o=0, failed_o=000, err_cnt_o=0.
- CNT_W=4, 20 mismatch samples -> err_cnt_o saturates at 15. With CV32E40P_VOTER_DIAG_EN, first mismatch res1=0x0F vs voted 0x00 -> diag_syndrome_o=0x0F, diag_replica_o=1, held thereafter.
